// File: rtl/gf180mcu_osu_sc_gp12t3v3__elastic_buf_if.sv
// Handshake bundle for the elastic buffer: producer side (A*), consumer side (Y*)
// and occupancy status. master = the surrounding logic, slave = the buffer.
interface gf180mcu_osu_sc_gp12t3v3__elastic_buf_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] A;
    logic             A_VALID;
    logic             A_READY;
    logic [WIDTH-1:0] Y;
    logic             Y_VALID;
    logic             Y_READY;
    logic [CW-1:0]    COUNT;
    logic             FULL;
    logic             EMPTY;

    modport master (
        output A, A_VALID, Y_READY,
        input  A_READY, Y, Y_VALID, COUNT, FULL, EMPTY
    );

    modport slave (
        input  A, A_VALID, Y_READY,
        output A_READY, Y, Y_VALID, COUNT, FULL, EMPTY
    );
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__elastic_buf.sv
// WIDTH x DEPTH elastic buffer with valid/ready on both sides; optional
// zero-latency fall-through when empty (PASS=1).
module gf180mcu_osu_sc_gp12t3v3__elastic_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PASS  = 0
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_osu_sc_gp12t3v3__elastic_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             full, empty, a_ready, y_valid;
    logic [WIDTH-1:0] y;
    logic             push, pop, bypass, store, pop_stored;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        a_ready = !full && !RST;
        push    = bus.A_VALID && a_ready;

        // In fall-through mode an empty buffer exposes the producer directly.
        if ((PASS != 0) && empty) begin
            y_valid = bus.A_VALID && !RST;
            y       = RST ? '0 : bus.A;
        end else begin
            y_valid = !empty;
            y       = empty ? '0 : mem_q[rd_ptr_q];
        end

        pop        = y_valid && bus.Y_READY;
        bypass     = (PASS != 0) && empty && push && bus.Y_READY;
        store      = push && !bypass;
        pop_stored = pop && !empty;

        wr_ptr_d = store      ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_stored ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (store && !pop_stored) begin
            count_d = count_q + CW'(1);
        end else if (pop_stored && !store) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (store) begin
            mem_q[wr_ptr_q] <= bus.A;
        end
    end

    assign bus.A_READY = a_ready;
    assign bus.Y       = y;
    assign bus.Y_VALID = y_valid;
    assign bus.COUNT   = count_q;
    assign bus.FULL    = full;
    assign bus.EMPTY   = empty;
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__elastic_buf.sv
// Directed bench: one registered buffer (PASS=0) and one fall-through buffer
// (PASS=1), both WIDTH=8 DEPTH=4, sharing clock and reset.
module tb_gf180mcu_osu_sc_gp12t3v3__elastic_buf;
    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_gp12t3v3__elastic_buf_if #(.WIDTH(8), .DEPTH(4)) p0 ();
    gf180mcu_osu_sc_gp12t3v3__elastic_buf_if #(.WIDTH(8), .DEPTH(4)) p1 ();

    gf180mcu_osu_sc_gp12t3v3__elastic_buf #(.WIDTH(8), .DEPTH(4), .PASS(0)) dut_reg (
        .CLK (CLK),
        .RST (RST),
        .bus (p0.slave)
    );

    gf180mcu_osu_sc_gp12t3v3__elastic_buf #(.WIDTH(8), .DEPTH(4), .PASS(1)) dut_pass (
        .CLK (CLK),
        .RST (RST),
        .bus (p1.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fill_w [4];
        int in_idx;
        int out_idx;
        int cyc;

        fill_w = '{8'h11, 8'h22, 8'h33, 8'h44};

        RST = 1'b1;
        p0.A = 8'hEE; p0.A_VALID = 1'b1; p0.Y_READY = 1'b0;
        p1.A = 8'h00; p1.A_VALID = 1'b0; p1.Y_READY = 1'b0;

        // reset with producer pushing
        #1;
        check_val("rst_a_ready", p0.A_READY, 0);
        check_val("rst_y_valid", p0.Y_VALID, 0);
        tick();
        check_val("rst_count", p0.COUNT, 0);
        check_val("rst_empty", p0.EMPTY, 1);
        check_val("rst_full", p0.FULL, 0);
        check_val("rst_y", p0.Y, 0);
        check_val("rst_a_ready2", p0.A_READY, 0);
        tick();
        check_val("rst_count2", p0.COUNT, 0);
        check_val("rst_y_valid2", p0.Y_VALID, 0);
        RST = 1'b0;
        p0.A_VALID = 1'b0;
        #1;
        check_val("post_rst_a_ready", p0.A_READY, 1);
        check_val("post_rst_no_write", p0.Y_VALID, 0);

        // fill
        for (int i = 0; i < 4; i++) begin
            p0.A = fill_w[i];
            p0.A_VALID = 1'b1;
            #1;
            check_val("fill_a_ready", p0.A_READY, 1);
            tick();
        end
        p0.A = 8'h55;
        #1;
        check_val("full_count", p0.COUNT, 4);
        check_val("full_flag", p0.FULL, 1);
        check_val("full_a_ready", p0.A_READY, 0);
        check_val("full_y", p0.Y, 8'h11);
        check_val("full_y_valid", p0.Y_VALID, 1);
        tick();
        check_val("full_hold_count", p0.COUNT, 4);
        check_val("full_hold_y", p0.Y, 8'h11);

        // pop at full: 5th word still refused
        p0.Y_READY = 1'b1;
        #1;
        check_val("full_pop_a_ready", p0.A_READY, 0);
        check_val("drain_y0", p0.Y, 8'h11);
        tick();
        p0.A_VALID = 1'b0;
        #1;
        check_val("full_pop_count", p0.COUNT, 3);
        check_val("full_pop_a_ready_next", p0.A_READY, 1);
        check_val("drain_y1", p0.Y, 8'h22);
        tick();
        check_val("drain_y2", p0.Y, 8'h33);
        tick();
        check_val("drain_y3", p0.Y, 8'h44);
        tick();
        check_val("drain_empty", p0.EMPTY, 1);
        check_val("drain_y_zero", p0.Y, 0);
        check_val("drain_y_valid", p0.Y_VALID, 0);
        check_val("drain_count", p0.COUNT, 0);

        // stream 10 words with consumer ready every other cycle
        in_idx = 0;
        out_idx = 0;
        cyc = 0;
        while (out_idx < 10 && cyc < 100) begin
            p0.A_VALID = (in_idx < 10);
            p0.A = 8'(in_idx);
            p0.Y_READY = (cyc % 2 == 1);
            #1;
            if (p0.Y_VALID && p0.Y_READY) begin
                check_val("wrap_order", p0.Y, 32'(out_idx));
                out_idx++;
            end
            if (p0.A_VALID && p0.A_READY) in_idx++;
            tick();
            cyc++;
        end
        p0.A_VALID = 1'b0;
        p0.Y_READY = 1'b0;
        #1;
        check_val("wrap_out_total", out_idx, 10);
        check_val("wrap_count", p0.COUNT, 0);

        // simultaneous push/pop at COUNT=2
        p0.A = 8'h61; p0.A_VALID = 1'b1;
        tick();
        p0.A = 8'h62;
        tick();
        p0.A = 8'h63; p0.Y_READY = 1'b1;
        #1;
        check_val("pp_count_before", p0.COUNT, 2);
        check_val("pp_y_before", p0.Y, 8'h61);
        tick();
        p0.A_VALID = 1'b0; p0.Y_READY = 1'b0;
        #1;
        check_val("pp_count_after", p0.COUNT, 2);
        check_val("pp_y_after", p0.Y, 8'h62);

        // mid-operation reset at COUNT=3
        p0.A = 8'h64; p0.A_VALID = 1'b1;
        tick();
        p0.A_VALID = 1'b0;
        #1;
        check_val("mid_count3", p0.COUNT, 3);
        RST = 1'b1; p0.A_VALID = 1'b1; p0.Y_READY = 1'b1;
        tick();
        RST = 1'b0; p0.A_VALID = 1'b0; p0.Y_READY = 1'b0;
        #1;
        check_val("mid_rst_count", p0.COUNT, 0);
        check_val("mid_rst_y_valid", p0.Y_VALID, 0);
        check_val("mid_rst_empty", p0.EMPTY, 1);
        p0.A = 8'h7E; p0.A_VALID = 1'b1;
        #1;
        check_val("lat_y_valid_same", p0.Y_VALID, 0);
        tick();
        p0.A_VALID = 1'b0;
        #1;
        check_val("lat_y_next", p0.Y, 8'h7E);
        check_val("lat_y_valid_next", p0.Y_VALID, 1);
        check_val("lat_count", p0.COUNT, 1);
        p0.Y_READY = 1'b1;
        tick();
        p0.Y_READY = 1'b0;

        // fall-through buffer
        p1.A = 8'hA5; p1.A_VALID = 1'b1; p1.Y_READY = 1'b1;
        #1;
        check_val("pass_y", p1.Y, 8'hA5);
        check_val("pass_y_valid", p1.Y_VALID, 1);
        check_val("pass_count_before", p1.COUNT, 0);
        tick();
        p1.Y_READY = 1'b0;
        #1;
        check_val("pass_count_after", p1.COUNT, 0);
        check_val("pass_stall_y", p1.Y, 8'hA5);
        check_val("pass_stall_y_valid", p1.Y_VALID, 1);
        tick();
        p1.A_VALID = 1'b0; p1.A = 8'h00;
        #1;
        check_val("pass_stored_count", p1.COUNT, 1);
        check_val("pass_stored_y", p1.Y, 8'hA5);
        check_val("pass_stored_y_valid", p1.Y_VALID, 1);
        tick();
        check_val("pass_hold_y", p1.Y, 8'hA5);
        p1.Y_READY = 1'b1;
        tick();
        p1.Y_READY = 1'b0;
        #1;
        check_val("pass_drained_count", p1.COUNT, 0);
        check_val("pass_drained_y_valid", p1.Y_VALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
